// File: rtl/dense_layer_sequencer_pkg.sv
// Shared definitions for the dense-layer readout sequencer: sequencer states
// and the accelerator geometry it reads back.
package dense_seq_pkg;

  localparam int N_OUT  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KICK      = 3'd1,
    WAIT_DONE = 3'd2,
    SETTLE    = 3'd3,
    READ      = 3'd4,
    OUT       = 3'd5,
    FINISH    = 3'd6
  } state_t;

  function automatic logic is_last(input logic [ADDR_W-1:0] idx);
    return idx == ADDR_W'(N_OUT - 1);
  endfunction

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// Job request, accelerator control/readback and result stream of the sequencer.
interface dense_layer_sequencer_if;
  import dense_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              busy;
  logic              acc_start;
  logic              acc_done;
  logic [ADDR_W-1:0] acc_read_addr;
  logic [DATA_W-1:0] acc_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              result_valid;
  logic [ADDR_W-1:0] argmax_index;
  logic [DATA_W-1:0] argmax_value;
  logic              timeout_err;

  modport master (
    input  req_valid, acc_done, acc_read_data, out_ready,
    output req_ready, busy, acc_start, acc_read_addr, out_valid, out_data,
           out_index, out_last, result_valid, argmax_index, argmax_value,
           timeout_err
  );

  modport slave (
    output req_valid, acc_done, acc_read_data, out_ready,
    input  req_ready, busy, acc_start, acc_read_addr, out_valid, out_data,
           out_index, out_last, result_valid, argmax_index, argmax_value,
           timeout_err
  );

endinterface

// File: rtl/dense_layer_sequencer_argmax_tracker.sv
// Running signed maximum with its index; strictly-greater replaces so ties
// keep the earliest index, and the first element after clear always loads.
module argmax_tracker
  import dense_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] value,
  input  logic        [ADDR_W-1:0] index,
  output logic signed [DATA_W-1:0] max_val,
  output logic        [ADDR_W-1:0] max_idx
);

  logic loaded;

  // Max/index register, cleared per job.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      loaded  <= 1'b0;
      max_val <= '0;
      max_idx <= '0;
    end else if (valid && (!loaded || value > max_val)) begin
      loaded  <= 1'b1;
      max_val <= value;
      max_idx <= index;
    end
  end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Starts the dense/BN/ReLU6 accelerator, waits for done with a timeout, then
// reads back every output, streams it with backpressure and tracks the argmax.
module dense_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter int SETTLE_CYC  = 5,
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic                     clk,
  input logic                     reset,
  dense_layer_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + SETTLE_CYC + READ_LAT + 2);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  idx_next;
  logic               accept;
  logic               capture;
  logic               handshake;
  logic               timeout;

  // Next-state logic; cnt counts job cycles during KICK/WAIT_DONE so the
  // first WAIT_DONE cycle is cnt==1, which is where a stale done is blanked.
  always_comb begin
    next_state = state;
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = idx;
    accept     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bus.req_valid) begin
          accept     = 1'b1;
          idx_next   = '0;
          next_state = KICK;
        end else begin
          next_state = IDLE;
        end
      end
      KICK: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.acc_done && cnt != CNT_W'(1)) begin
          cnt_next   = '0;
          next_state = SETTLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = WAIT_DONE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_next   = '0;
          next_state = READ;
        end else begin
          next_state = SETTLE;
        end
      end
      READ: begin
        if (cnt == CNT_W'(READ_LAT - 1)) begin
          capture    = 1'b1;
          cnt_next   = '0;
          next_state = OUT;
        end else begin
          next_state = READ;
        end
      end
      OUT: begin
        cnt_next = '0;
        if (bus.out_ready) begin
          handshake = 1'b1;
          if (is_last(idx)) begin
            next_state = FINISH;
          end else begin
            idx_next   = idx + ADDR_W'(1);
            next_state = READ;
          end
        end else begin
          next_state = OUT;
        end
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      bus.req_ready    <= 1'b1;
      bus.busy         <= 1'b0;
      bus.acc_start    <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_index    <= '0;
      bus.out_last     <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      state            <= next_state;
      cnt              <= cnt_next;
      idx              <= idx_next;
      bus.req_ready    <= (next_state == IDLE);
      bus.busy         <= (next_state != IDLE);
      bus.acc_start    <= (next_state == KICK);
      bus.out_valid    <= (next_state == OUT);
      bus.result_valid <= (next_state == FINISH);
      if (accept) begin
        bus.timeout_err <= 1'b0;
      end else if (timeout) begin
        bus.timeout_err <= 1'b1;
      end
      if (accept) begin
        bus.out_data  <= '0;
        bus.out_index <= '0;
        bus.out_last  <= 1'b0;
      end else if (capture) begin
        bus.out_data  <= bus.acc_read_data;
        bus.out_index <= idx;
        bus.out_last  <= is_last(idx);
      end else if (handshake) begin
        bus.out_last  <= 1'b0;
      end
    end
  end

  assign bus.acc_read_addr = idx;

  argmax_tracker u_argmax (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .valid   (handshake),
    .value   (bus.out_data),
    .index   (bus.out_index),
    .max_val (bus.argmax_value),
    .max_idx (bus.argmax_index)
  );

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Self-checking bench: accelerator model with programmable done behaviour,
// randomized backpressure and a queue/array reference of the readout.
module tb_dense_layer_sequencer;
  import dense_seq_pkg::*;

  localparam int SETTLE = 5;
  localparam int RL     = 1;
  localparam int TO     = 100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dense_layer_sequencer_if bus ();

  dense_layer_sequencer #(
    .SETTLE_CYC  (SETTLE),
    .READ_LAT    (RL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int since = 0;
  int done_mode = 0;   // 0: done window after start, 1: never, 2: always high
  int done_dly  = 40;

  logic [DATA_W-1:0] mem [0:N_OUT-1];

  // Accelerator model: done level relative to the last start pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.acc_start) since <= 1;
    else if (since != 0) since <= since + 1;
  end
  assign bus.acc_done = (done_mode == 2) ||
                        (done_mode == 0 && since >= done_dly && since < done_dly + 4);
  assign bus.acc_read_data = mem[bus.acc_read_addr];

  // Observations of the most recent job.
  logic [ADDR_W-1:0] beat_idx [$];
  logic [DATA_W-1:0] beat_data[$];
  logic              beat_last[$];
  int n_result, n_starts, stall_viol, start_cyc, done_cyc, ov_cyc, res_cyc;
  logic [ADDR_W-1:0] res_idx;
  logic [DATA_W-1:0] res_val;

  function automatic int seq_errors();
    int e = 0;
    for (int i = 0; i < beat_idx.size(); i++) begin
      if (beat_idx[i] !== ADDR_W'(i) || beat_data[i] !== mem[i] ||
          beat_last[i] !== (i == N_OUT - 1)) e++;
    end
    return e;
  endfunction

  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < N_OUT; i++)
      if ($signed(mem[i]) > $signed(mem[best])) best = i;
    return best;
  endfunction

  task automatic load_nominal();
    for (int i = 0; i < N_OUT; i++) mem[i] = (i == N_OUT - 1) ? 4'd6 : 4'((i % 7) - 1);
  endtask

  task automatic run_job(input int ready_pct, input bit hold_req);
    int post = -1;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] p_data = '0;
    logic [ADDR_W-1:0] p_idx = '0;
    logic p_last = 1'b0;
    beat_idx.delete(); beat_data.delete(); beat_last.delete();
    n_result = 0; n_starts = 0; stall_viol = 0;
    start_cyc = -1; done_cyc = -1; ov_cyc = -1; res_cyc = -1;
    res_idx = '0; res_val = '0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4000 && post != 0; k++) begin
      @(negedge clk);
      if (!hold_req) bus.req_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
      if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== p_data ||
                      bus.out_index !== p_idx || bus.out_last !== p_last)) stall_viol++;
      if (bus.acc_start) begin
        n_starts++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (start_cyc >= 0 && done_cyc < 0 && cyc >= start_cyc + 2 && bus.acc_done) done_cyc = cyc;
      if (bus.out_valid && ov_cyc < 0) ov_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        beat_idx.push_back(bus.out_index);
        beat_data.push_back(bus.out_data);
        beat_last.push_back(bus.out_last);
      end
      stalled = bus.out_valid && !bus.out_ready;
      p_data = bus.out_data; p_idx = bus.out_index; p_last = bus.out_last;
      if (bus.result_valid) begin
        n_result++;
        if (res_cyc < 0) begin
          res_cyc = cyc; res_idx = bus.argmax_index; res_val = bus.argmax_value;
        end
        post = 2;
      end
      if (post > 0) post--;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.acc_start !== 1'b0) begin bad++; $display("FAIL reset_acc_start: got %b want 0", bus.acc_start); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid: got %b want 0", bus.result_valid); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    total++; if (bus.acc_read_addr !== 7'd0 || bus.argmax_index !== 7'd0 || bus.argmax_value !== 4'd0)
      begin bad++; $display("FAIL reset_addr_argmax: got %0d/%0d/%0d want 0/0/0", bus.acc_read_addr, bus.argmax_index, bus.argmax_value); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL idle_after_reset: busy=%b ready=%b want 0/1", bus.busy, bus.req_ready); end
  endtask

  task automatic test_nominal();
    load_nominal(); done_mode = 0; done_dly = 40;
    run_job(100, 1'b0);
    total++; if (beat_idx.size() !== N_OUT) begin bad++; $display("FAIL nom_beats: got %0d want %0d", beat_idx.size(), N_OUT); end
    total++; if (seq_errors() !== 0) begin bad++; $display("FAIL nom_sequence: got %0d bad beats want 0", seq_errors()); end
    total++; if (n_result !== 1) begin bad++; $display("FAIL nom_result_pulses: got %0d want 1", n_result); end
    total++; if (n_starts !== 1) begin bad++; $display("FAIL nom_starts: got %0d want 1", n_starts); end
    total++; if (res_idx !== 7'd127 || res_val !== 4'd6) begin bad++; $display("FAIL nom_argmax: got %0d/%0d want 127/6", res_idx, $signed(res_val)); end
    total++; if (ov_cyc - start_cyc !== done_cyc - start_cyc + 1 + SETTLE + RL)
      begin bad++; $display("FAIL nom_latency: got %0d want %0d", ov_cyc - start_cyc, done_cyc - start_cyc + 1 + SETTLE + RL); end
    total++; if (res_cyc - ov_cyc !== (N_OUT - 1) * (RL + 1) + 1)
      begin bad++; $display("FAIL nom_throughput: got %0d want %0d", res_cyc - ov_cyc, (N_OUT - 1) * (RL + 1) + 1); end
    repeat (5) @(negedge clk);
    total++; if (bus.argmax_index !== 7'd127 || bus.busy !== 1'b0) begin bad++; $display("FAIL nom_argmax_hold: got %0d busy=%b want 127 busy=0", bus.argmax_index, bus.busy); end
  endtask

  task automatic test_backpressure();
    load_nominal(); done_mode = 0;
    run_job(30, 1'b0);
    total++; if (beat_idx.size() !== N_OUT) begin bad++; $display("FAIL bp_beats: got %0d want %0d", beat_idx.size(), N_OUT); end
    total++; if (seq_errors() !== 0) begin bad++; $display("FAIL bp_sequence: got %0d bad beats want 0", seq_errors()); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes under stall want 0", stall_viol); end
    total++; if (n_result !== 1 || res_idx !== 7'd127) begin bad++; $display("FAIL bp_result: got %0d pulses idx %0d want 1/127", n_result, res_idx); end
  endtask

  task automatic test_ties_negative();
    for (int i = 0; i < N_OUT; i++) mem[i] = 4'hE;
    mem[5] = 4'd3; mem[90] = 4'd3;
    run_job(70, 1'b0);
    total++; if (seq_errors() !== 0 || beat_idx.size() !== N_OUT) begin bad++; $display("FAIL tie_sequence: got %0d beats %0d bad want %0d/0", beat_idx.size(), seq_errors(), N_OUT); end
    total++; if (res_idx !== 7'd5 || res_val !== 4'd3) begin bad++; $display("FAIL tie_argmax: got %0d/%0d want 5/3", res_idx, $signed(res_val)); end
  endtask

  task automatic test_random_data();
    int best;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_OUT; i++) mem[i] = 4'($urandom_range(0, 15));
      best = ref_argmax();
      run_job(60, 1'b0);
      total++; if (seq_errors() !== 0 || beat_idx.size() !== N_OUT) begin bad++; $display("FAIL rnd_sequence: got %0d beats %0d bad want %0d/0", beat_idx.size(), seq_errors(), N_OUT); end
      total++; if (res_idx !== 7'(best) || res_val !== mem[best]) begin bad++; $display("FAIL rnd_argmax: got %0d/%0d want %0d/%0d", res_idx, $signed(res_val), best, $signed(mem[best])); end
    end
  endtask

  task automatic test_timeout();
    int t_start = -1;
    int t_err = -1;
    int waited = 0;
    bit saw_ov = 1'b0;
    logic busy_pre = 1'bx, err_pre = 1'bx, busy_err = 1'bx;
    done_mode = 1; bus.out_ready = 1'b1;
    @(negedge clk); bus.req_valid = 1'b1;
    for (int k = 0; k < 300 && t_err < 0; k++) begin
      @(negedge clk); bus.req_valid = 1'b0;
      if (bus.acc_start && t_start < 0) t_start = cyc;
      if (bus.out_valid) saw_ov = 1'b1;
      if (t_start >= 0 && cyc == t_start + TO) begin busy_pre = bus.busy; err_pre = bus.timeout_err; end
      if (bus.timeout_err && t_err < 0) begin t_err = cyc; busy_err = bus.busy; end
    end
    total++; if (t_err - t_start !== TO + 1) begin bad++; $display("FAIL to_cycle: got %0d want %0d", t_err - t_start, TO + 1); end
    total++; if (err_pre !== 1'b0 || busy_pre !== 1'b1) begin bad++; $display("FAIL to_early: err=%b busy=%b want 0/1", err_pre, busy_pre); end
    total++; if (busy_err !== 1'b0) begin bad++; $display("FAIL to_busy: got %b want 0", busy_err); end
    total++; if (saw_ov !== 1'b0) begin bad++; $display("FAIL to_no_out: got %b want 0", saw_ov); end
    repeat (5) @(negedge clk);
    total++; if (bus.timeout_err !== 1'b1 || bus.result_valid !== 1'b0) begin bad++; $display("FAIL to_sticky: err=%b rv=%b want 1/0", bus.timeout_err, bus.result_valid); end
    done_mode = 0; load_nominal();
    bus.req_valid = 1'b1;
    @(negedge clk); bus.req_valid = 1'b0;
    total++; if (bus.acc_start !== 1'b1 || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: start=%b err=%b want 1/0", bus.acc_start, bus.timeout_err); end
    while (bus.busy && waited < 2000) begin @(negedge clk); waited++; end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_drain: got busy=%b want 0 within bound", bus.busy); end
  endtask

  task automatic test_reset_midjob();
    bit hit = 1'b0;
    int bad_after = 0;
    load_nominal(); done_mode = 0; bus.out_ready = 1'b1;
    @(negedge clk); bus.req_valid = 1'b1;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk); bus.req_valid = 1'b0;
      if (bus.out_valid && bus.out_index == 7'd60) begin hit = 1'b1; bus.out_ready = 1'b0; reset = 1'b1; end
    end
    @(negedge clk);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rst_reach60: got %b want 1", hit); end
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1)
      begin bad++; $display("FAIL rst_abort: valid=%b busy=%b ready=%b want 0/0/1", bus.out_valid, bus.busy, bus.req_ready); end
    reset = 1'b0; bus.out_ready = 1'b1;
    repeat (20) begin @(negedge clk); if (bus.acc_start || bus.out_valid) bad_after++; end
    total++; if (bad_after !== 0) begin bad++; $display("FAIL rst_quiet: got %0d active cycles want 0", bad_after); end
    run_job(100, 1'b0);
    total++; if (beat_idx.size() !== N_OUT || seq_errors() !== 0 || n_result !== 1)
      begin bad++; $display("FAIL rst_restart: got %0d beats %0d bad %0d pulses want %0d/0/1", beat_idx.size(), seq_errors(), n_result, N_OUT); end
  endtask

  task automatic test_stale_done();
    load_nominal(); done_mode = 2;
    run_job(100, 1'b0);
    total++; if (ov_cyc - start_cyc !== 2 + 1 + SETTLE + RL) begin bad++; $display("FAIL stale_latency: got %0d want %0d", ov_cyc - start_cyc, 2 + 1 + SETTLE + RL); end
    total++; if (n_starts !== 1) begin bad++; $display("FAIL stale_starts: got %0d want 1", n_starts); end
    total++; if (seq_errors() !== 0 || beat_idx.size() !== N_OUT) begin bad++; $display("FAIL stale_sequence: got %0d beats %0d bad want %0d/0", beat_idx.size(), seq_errors(), N_OUT); end
    done_mode = 0;
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    load_nominal(); done_mode = 0;
    run_job(100, 1'b1);
    total++; if (n_starts !== 1 || n_result !== 1) begin bad++; $display("FAIL b2b_first: got %0d starts %0d pulses want 1/1", n_starts, n_result); end
    @(negedge clk);
    total++; if (bus.acc_start !== 1'b1) begin bad++; $display("FAIL b2b_restart: got %b want 1", bus.acc_start); end
    bus.req_valid = 1'b0;
    while (bus.busy && waited < 2000) begin @(negedge clk); waited++; end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_drain: got busy=%b want 0 within bound", bus.busy); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;
    load_nominal();
    test_reset();
    test_nominal();
    test_backpressure();
    test_ties_negative();
    test_random_data();
    test_timeout();
    test_reset_midjob();
    test_stale_done();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_layer_sequencer.md
Name: dense_layer_sequencer

Overview:
- Controller for the 1x1280->256->128 dense/BN/ReLU6 accelerator (start/done/read_addr/read_data interface).
- Accepts a job request and issues the one-cycle start pulse; it then waits for done with a timeout.
- It sweeps read_addr 0..127 and streams the 4-bit signed results out over a valid/ready port with backpressure.
- It also computes the argmax over the 128 outputs, which the classifier consumes.

Parameters:
N_OUT, 128, number of accelerator outputs read back
ADDR_W, 7, accelerator read address width
DATA_W, 4, accelerator output width (signed, ReLU6-quantised)
READ_LAT, 1, cycles from acc_read_addr change to valid acc_read_data
SETTLE_CYC, 5, idle cycles inserted between done and the first read
TIMEOUT_CYC, 1000000, max cycles to wait for acc_done before error

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  job request
req_ready  out  1  high only in IDLE; job accepted on req_valid&&req_ready
busy  out  1  high in every state except IDLE
acc_start  out  1  one-cycle start pulse to accelerator
acc_done  in  1  accelerator done (level)
acc_read_addr  out  ADDR_W  accelerator readback address
acc_read_data  in  DATA_W  accelerator readback data
out_valid  out  1  result element valid
out_ready  in  1  downstream ready
out_data  out  DATA_W  signed element value
out_index  out  ADDR_W  element index
out_last  out  1  high with out_valid when out_index==N_OUT-1
result_valid  out  1  one-cycle pulse after last element handshake
argmax_index  out  ADDR_W  index of maximum element (held until next job)
argmax_value  out  DATA_W  maximum value (signed)
timeout_err  out  1  sticky; cleared on next job acceptance

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready=1. Reset mid-job aborts immediately; no further acc_start or out_valid is produced.
- IDLE: on req_valid&&req_ready, clear timeout_err, argmax regs and counters, then go KICK.
- KICK: acc_start=1 for exactly this cycle, then go WAIT_DONE.
- WAIT_DONE: acc_done is ignored in the first cycle (blanking for a stale done). From the second cycle, acc_done=1 goes SETTLE.
- WAIT_DONE timeout: the cycle counter reaching TIMEOUT_CYC sets timeout_err=1 and goes IDLE. result_valid is not pulsed on a timeout.
- SETTLE: counts SETTLE_CYC cycles with acc_read_addr=0, then goes READ.
- READ: acc_read_addr=idx is held stable. After READ_LAT cycles, capture acc_read_data into out_data, set out_index=idx and out_valid=1, then go OUT.
- OUT: out_valid, out_data, out_index and out_last stay stable until out_ready=1. Data must not change under backpressure.
- OUT handshake cycle: update argmax. Then, if idx==N_OUT-1, go FINISH; else idx+1 and go READ.
- FINISH: result_valid=1 for one cycle, then go IDLE. argmax outputs hold until the next accepted job.
- Argmax: signed compare and strictly-greater replaces, so ties keep the lowest index. Element 0 always loads.
- Throughput: one element per READ_LAT+1 cycles when out_ready is held high.
- Latency: req accept to first out_valid = 1 + done latency + SETTLE_CYC + READ_LAT cycles.
- req_valid is ignored while busy.
- acc_done deasserting mid-readout is ignored.
- out_ready held high outside OUT has no effect.

Decomposition:
- Package dense_seq_pkg holds:
  - the state enum (IDLE, KICK, WAIT_DONE, SETTLE, READ, OUT, FINISH);
  - N_OUT/ADDR_W/DATA_W constants shared with the accelerator.
- Sub-module argmax_tracker holds the signed running max plus index. Its inputs are clear, valid, value and index; its outputs are max_val and max_idx.

Test Plan:
- Nominal: accelerator model sets done 40 cycles after start; data[i] = (i%7)-1 for i<127, data[127]=6. Expect:
  - 128 beats, indices 0..127, with out_last only on 127;
  - argmax_index=127, argmax_value=6, one result_valid pulse.
- Backpressure: out_ready random 30% duty on the same data. Expect identical beat sequence, no beat dropped or duplicated, and out_data stable while out_valid&&!out_ready.
- Ties and negatives: all elements -2 except data[5]=data[90]=3. Expect argmax_index=5, argmax_value=3.
- Timeout: TIMEOUT_CYC=100, acc_done never asserts. Expect:
  - timeout_err=1 at cycle 101 after accept, busy=0, no out_valid;
  - next request clears timeout_err.
- Reset mid-readout: assert reset at element 60 in OUT. Expect next cycle out_valid=0, busy=0, req_ready=1; then a new job restarts at index 0.
- Stale done: acc_done held 1 from the previous job through KICK. Expect SETTLE entered no earlier than the second WAIT_DONE cycle and exactly one acc_start pulse per job.
